// File: rtl/ecc_pkg.sv
// Shared definitions for the SEC-DED Hamming codec family (decoder and encoder).
package ecc_pkg;

    // Operating mode as carried on work_mod.
    typedef enum logic [1:0] {
        MODE_ILLEGAL = 2'b00,
        MODE_8_4     = 2'b01,
        MODE_16_11   = 2'b10,
        MODE_32_26   = 2'b11
    } work_mode_e;

    // Decode outcome as reported on num_of_errors.
    typedef enum logic [1:0] {
        ERR_NONE   = 2'd0,
        ERR_SINGLE = 2'd1,
        ERR_DOUBLE = 2'd2,
        ERR_MODE   = 2'd3
    } err_code_e;

    // Widest geometry; all datapaths are built for this size.
    localparam int unsigned MAX_N = 32'd32;
    localparam int unsigned MAX_K = 32'd26;
    localparam int unsigned MAX_M = 32'd5;

    // Per-mode geometry: N = K + 1 + m.
    localparam int unsigned N_8  = 32'd8;
    localparam int unsigned K_8  = 32'd4;
    localparam int unsigned M_8  = 32'd3;
    localparam int unsigned N_16 = 32'd16;
    localparam int unsigned K_16 = 32'd11;
    localparam int unsigned M_16 = 32'd4;
    localparam int unsigned N_32 = 32'd32;
    localparam int unsigned K_32 = 32'd26;
    localparam int unsigned M_32 = 32'd5;

    // Column code of each info bit: ascending non-power-of-two values.
    // The list for a smaller m is a prefix of the list for a larger m,
    // so one table serves all modes.
    localparam logic [4:0] COL_CODE [0:25] = '{
        5'd3,  5'd5,  5'd6,  5'd7,  5'd9,  5'd10, 5'd11, 5'd12, 5'd13,
        5'd14, 5'd15, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21, 5'd22, 5'd23,
        5'd24, 5'd25, 5'd26, 5'd27, 5'd28, 5'd29, 5'd30, 5'd31
    };

    // Bits of the codeword that belong to the selected mode.
    function automatic logic [31:0] codeword_mask(input work_mode_e md);
        case (md)
            MODE_8_4:   return 32'hFFFF_FFFF >> (MAX_N - N_8);
            MODE_16_11: return 32'hFFFF_FFFF >> (MAX_N - N_16);
            MODE_32_26: return 32'hFFFF_FFFF >> (MAX_N - N_32);
            default:    return 32'h0000_0000;
        endcase
    endfunction

    // Bits of the info word that belong to the selected mode.
    function automatic logic [25:0] info_mask(input work_mode_e md);
        case (md)
            MODE_8_4:   return 26'h3FF_FFFF >> (MAX_K - K_8);
            MODE_16_11: return 26'h3FF_FFFF >> (MAX_K - K_16);
            MODE_32_26: return 26'h3FF_FFFF >> (MAX_K - K_32);
            default:    return 26'h000_0000;
        endcase
    endfunction

    // Even-parity reduction over a full-width codeword.
    function automatic logic even_parity32(input logic [31:0] v);
        return ^v;
    endfunction

    // Hamming check bits of a (pre-masked) info word: p(j) covers every
    // info bit whose column code has bit j set.
    function automatic logic [4:0] calc_checks(input logic [25:0] info);
        logic [4:0] chk;
        chk = 5'b00000;
        for (int i = 0; i < 26; i++) begin
            for (int j = 0; j < 5; j++) begin
                if (COL_CODE[i][j]) begin
                    chk[j] = chk[j] ^ info[i];
                end else begin
                    chk[j] = chk[j];
                end
            end
        end
        return chk;
    endfunction

endpackage

// File: rtl/dec_syndrome.sv
// Decoder stage 1: masks the codeword to its mode, computes the Hamming
// syndrome and the overall parity, and registers them with the info bits.
module dec_syndrome
    import ecc_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [MAX_N-1:0] codeword,
    input  logic             cw_valid,
    input  logic [1:0]       cw_mode,
    output logic [MAX_M-1:0] syndrome,
    output logic             parity_odd,
    output logic [MAX_K-1:0] info,
    output work_mode_e       mode,
    output logic             valid
);

    work_mode_e       mode_s;
    logic [MAX_N-1:0] cw_s;
    logic [MAX_K-1:0] info_s;
    logic [MAX_M-1:0] rx_chk_s;
    logic [MAX_M-1:0] syn_s;
    logic             par_s;

    logic [MAX_M-1:0] syn_r;
    logic             par_r;
    logic [MAX_K-1:0] info_r;
    work_mode_e       mode_r;
    logic             valid_r;

    // Extract the mode's fields and form syndrome and overall parity.
    always_comb begin
        mode_s = work_mode_e'(cw_mode);
        cw_s   = codeword & codeword_mask(mode_s);
        info_s = cw_s[MAX_K-1:0] & info_mask(mode_s);
        case (mode_s)
            MODE_8_4:   rx_chk_s = MAX_M'(cw_s[K_8 + 32'd1 +: M_8]);
            MODE_16_11: rx_chk_s = MAX_M'(cw_s[K_16 + 32'd1 +: M_16]);
            MODE_32_26: rx_chk_s = MAX_M'(cw_s[K_32 + 32'd1 +: M_32]);
            default:    rx_chk_s = 5'b00000;
        endcase
        syn_s = rx_chk_s ^ calc_checks(info_s);
        par_s = even_parity32(cw_s);
    end

    // Stage-1 register; an idle cycle loads a bubble and keeps the payload.
    always_ff @(posedge clk) begin
        if (rst) begin
            syn_r   <= 5'b00000;
            par_r   <= 1'b0;
            info_r  <= 26'd0;
            mode_r  <= MODE_ILLEGAL;
            valid_r <= 1'b0;
        end else begin
            valid_r <= cw_valid;
            if (cw_valid) begin
                syn_r  <= syn_s;
                par_r  <= par_s;
                info_r <= info_s;
                mode_r <= mode_s;
            end
        end
    end

    assign syndrome   = syn_r;
    assign parity_odd = par_r;
    assign info       = info_r;
    assign mode       = mode_r;
    assign valid      = valid_r;

endmodule

// File: rtl/hamming_dec.sv
// Multi-mode SEC-DED Hamming decoder, two-stage pipeline, one word per cycle.
module hamming_dec
    import ecc_pkg::*;
#(
    parameter int MAX_CODEWORD_WIDTH = 32,
    parameter int MAX_INFO_WIDTH     = 26
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [MAX_CODEWORD_WIDTH-1:0] data_in,
    input  logic                          valid_in,
    input  logic [1:0]                    work_mod,
    output logic [MAX_INFO_WIDTH-1:0]     data_out,
    output logic [1:0]                    num_of_errors,
    output logic                          valid_out
);

    logic [MAX_N-1:0] cw_s;
    logic [MAX_M-1:0] s1_syn_s;
    logic             s1_par_s;
    logic [MAX_K-1:0] s1_info_s;
    work_mode_e       s1_mode_s;
    logic             s1_valid_s;

    logic [MAX_K-1:0] flip_s;
    logic [MAX_K-1:0] corr_info_s;
    err_code_e        err_s;

    logic [MAX_K-1:0] data_out_r;
    err_code_e        err_r;
    logic             valid_out_r;

    assign cw_s = MAX_N'(data_in);

    dec_syndrome u_syndrome (
        .clk        (clk),
        .rst        (rst),
        .codeword   (cw_s),
        .cw_valid   (valid_in),
        .cw_mode    (work_mod),
        .syndrome   (s1_syn_s),
        .parity_odd (s1_par_s),
        .info       (s1_info_s),
        .mode       (s1_mode_s),
        .valid      (s1_valid_s)
    );

    // Locate the info bit whose column code equals the syndrome.
    always_comb begin
        flip_s = 26'd0;
        for (int i = 0; i < 26; i++) begin
            if (COL_CODE[i] == s1_syn_s) begin
                flip_s[i] = 1'b1;
            end else begin
                flip_s[i] = 1'b0;
            end
        end
    end

    // Classify the word and apply the single-bit correction when allowed.
    always_comb begin
        corr_info_s = s1_info_s;
        err_s       = ERR_NONE;
        case (s1_mode_s)
            MODE_ILLEGAL: begin
                corr_info_s = 26'd0;
                err_s       = ERR_MODE;
            end
            default: begin
                if (s1_par_s) begin
                    // Odd overall parity: one bit flipped. A syndrome that is
                    // zero or a power of two hits no info column, so the flip
                    // mask stays empty and the info passes through.
                    corr_info_s = s1_info_s ^ (flip_s & info_mask(s1_mode_s));
                    err_s       = ERR_SINGLE;
                end else if (s1_syn_s != 5'b00000) begin
                    corr_info_s = s1_info_s;
                    err_s       = ERR_DOUBLE;
                end else begin
                    corr_info_s = s1_info_s;
                    err_s       = ERR_NONE;
                end
            end
        endcase
    end

    // Stage-2 output register; payload holds while no word is presented.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out_r  <= 26'd0;
            err_r       <= ERR_NONE;
            valid_out_r <= 1'b0;
        end else begin
            valid_out_r <= s1_valid_s;
            if (s1_valid_s) begin
                data_out_r <= corr_info_s;
                err_r      <= err_s;
            end
        end
    end

    assign data_out      = MAX_INFO_WIDTH'(data_out_r);
    assign num_of_errors = err_r;
    assign valid_out     = valid_out_r;

endmodule

// File: doc/hamming_dec.md
HAMMING_DEC -- requirements
Module: hamming_dec

Interface
REQ-001 Parameter MAX_CODEWORD_WIDTH, default 32: widest supported codeword.
REQ-002 Parameter MAX_INFO_WIDTH, default 26: widest supported info word.
REQ-003 clk  input  1: single clock; all state updates on the rising edge.
REQ-004 rst  input  1: synchronous, active-high reset.
REQ-005 data_in  input  MAX_CODEWORD_WIDTH: received codeword, LSB-aligned; bits at or above the mode's N are ignored.
REQ-006 valid_in  input  1: data_in and work_mod are sampled this cycle.
REQ-007 work_mod  input  2: 2'b01 = (N=8,K=4,m=3); 2'b10 = (16,11,4); 2'b11 = (32,26,5); 2'b00 is illegal.
REQ-008 data_out  output  MAX_INFO_WIDTH: corrected info word, bits at or above K driven zero.
REQ-009 num_of_errors  output  2: 0 = clean, 1 = corrected single error, 2 = uncorrectable double error, 3 = illegal mode.
REQ-010 valid_out  output  1: data_out and num_of_errors are valid this cycle.

Function
REQ-011 Codeword layout: bits [K-1:0] info, bit K overall even-parity bit over all N bits, bits [K+m:K+1] Hamming checks p0..p(m-1).
REQ-012 Info bit i is assigned column code = the i-th value, ascending, of the nonzero m-bit values that are not powers of two; p(j) covers info bits whose code has bit j set.
REQ-013 Syndrome s[j] = received p(j) XOR recomputed p(j); overall check P = XOR of all N received bits.
REQ-014 P=0, s=0: num_of_errors 0, info passed unchanged.
REQ-015 P=1, s equals info column code c: flip info bit c's index, num_of_errors 1.
REQ-016 P=1, s a power of two or zero: check/parity-bit error, info unchanged, num_of_errors 1.
REQ-017 P=0, s nonzero: num_of_errors 2, raw received info output, no correction.
REQ-018 work_mod 2'b00: data_out 0, num_of_errors 3, valid_out still asserted at normal latency.
REQ-019 Two-stage pipeline: stage 1 registers syndrome, P, info bits, mode, valid; stage 2 registers corrected outputs; latency exactly 2 cycles from valid_in to valid_out.
REQ-020 Full throughput: one codeword per cycle, no back-pressure; modes may change every cycle, each word decoded with its own sampled work_mod.
REQ-021 valid_in low: stage registers load a bubble; valid_out low two cycles later; data_out/num_of_errors hold their previous values while valid_out is low.

Reset
REQ-022 While rst is high at a clock edge: valid_out, both stage valids, data_out and num_of_errors clear to 0.
REQ-023 Reset mid-stream discards all in-flight words; first valid_out after reset release is 2 cycles after the first accepted valid_in.
REQ-024 valid_in asserted in the same cycle as rst is ignored.

Structure
REQ-025 Package ecc_pkg holds mode encodings, per-mode N/K/m constants, the column-code table, and the num_of_errors encodings; shared with the encoder.
REQ-026 One sub-module dec_syndrome (stage 1: syndrome and overall parity); hamming_dec instantiates it and implements stage 2 correction.

Verification
REQ-027 Mode 2'b01, data_in 8'h2B (info 4'hB, clean), valid_in=1 -> two cycles later data_out 26'h00000B, num_of_errors 0, valid_out 1.
REQ-028 Mode 2'b01, data_in 8'h29 (info bit 1 flipped) -> data_out 4'hB, num_of_errors 1.
REQ-029 Mode 2'b01, data_in 8'h3B (overall parity bit flipped) -> data_out 4'hB, num_of_errors 1; data_in 8'h28 (bits 0,1 flipped) -> data_out 4'h8, num_of_errors 2.
REQ-030 Back-to-back words in modes 01, 10, 11, 00 on consecutive cycles -> four consecutive valid_out cycles in order, last with num_of_errors 3 and data_out 0.
REQ-031 Random K-bit info per mode, encoder-compatible codeword, every single-bit flip over all N positions -> original info, num_of_errors 1; every double flip -> num_of_errors 2.
REQ-032 rst asserted one cycle after valid_in -> no valid_out from that word; outputs 0 until the next accepted word.
